intersection_scheduler: RTL and testbench

- Phase scheduler for the intersection lights. NS is the main road and rests green; EW is the side street, and its green is a shared resource granted on request.
- Arbitrates between the EW car sensor and the NS/EW pedestrian buttons, and sequences green -> yellow -> all-red per direction from an internal one-second tick prescaler.
- Drives the 6-bit lamp bus and the walk signals.

---
 rtl/intersection_scheduler.sv | 135 +++++++++++++
 tb/tb_intersection_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// Phase scheduler for a main-road / side-street intersection: NS rests green,
// EW green is granted on car or pedestrian request and timed from a one-second tick.
module intersection_scheduler #(
    parameter int TICK_DIV   = 50000000,
    parameter int GNS_MIN    = 10,
    parameter int GEW_MIN    = 5,
    parameter int GEW_MAX    = 15,
    parameter int YEL_SEC    = 2,
    parameter int ALLRED_SEC = 1,
    parameter int WALK_SEC   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       car_ew,
    input  logic       ped_ns,
    input  logic       ped_ew,
    output logic [5:0] lights,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase,
    output logic       sec_tick
);

    typedef enum logic [2:0] {
        GNS = 3'd0,
        YNS = 3'd1,
        RNS = 3'd2,
        GEW = 3'd3,
        YEW = 3'd4,
        REW = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0] GNS_MIN_C = 5'(GNS_MIN);
    localparam logic [4:0] GEW_MIN_C = 5'(GEW_MIN);
    localparam logic [4:0] GEW_MAX_C = 5'(GEW_MAX);
    localparam logic [4:0] YEL_C     = 5'(YEL_SEC);
    localparam logic [4:0] ALLRED_C  = 5'(ALLRED_SEC);
    localparam logic [4:0] WALK_C    = 5'(WALK_SEC);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    sec_cnt_q, sec_cnt_d, sec_nx;
    logic          ew_pend_q, ew_pend_d;
    logic          pns_pend_q, pns_pend_d;
    logic          pew_pend_q, pew_pend_d;
    logic          walk_ns_q, walk_ns_d;
    logic          walk_ew_q, walk_ew_d;
    logic [5:0]    lights_q, lights_d;
    logic          tick, changed, enter_gns, enter_gew, walk_done;

    always_comb begin
        tick      = (presc_q == TICK_LAST);
        sec_nx    = (sec_cnt_q == 5'd31) ? 5'd31 : sec_cnt_q + 5'd1;
        walk_done = tick && (sec_nx >= WALK_C);

        state_d = state_q;
        case (state_q)
            GNS: if (sec_cnt_q >= GNS_MIN_C && (ew_pend_q || pew_pend_q || pns_pend_q))
                     state_d = YNS;
            YNS: if (tick && sec_nx >= YEL_C)    state_d = RNS;
            RNS: if (tick && sec_nx >= ALLRED_C) state_d = GEW;
            // Extension: EW stays green while a car is present, up to the hard cap.
            GEW: if (tick && ((sec_nx >= GEW_MIN_C && !car_ew) || sec_nx >= GEW_MAX_C))
                     state_d = YEW;
            YEW: if (tick && sec_nx >= YEL_C)    state_d = REW;
            REW: if (tick && sec_nx >= ALLRED_C) state_d = GNS;
            default: state_d = GNS;
        endcase

        changed   = (state_d != state_q);
        enter_gns = (state_d == GNS) && (state_q != GNS);
        enter_gew = (state_d == GEW) && (state_q != GEW);

        if (changed) begin
            presc_d   = '0;
            sec_cnt_d = '0;
        end else begin
            presc_d   = tick ? '0 : presc_q + PW'(1);
            sec_cnt_d = tick ? sec_nx : sec_cnt_q;
        end

        // A request arriving on the entry edge is served by the phase being entered.
        ew_pend_d  = enter_gew ? 1'b0 : (ew_pend_q || (car_ew && state_q != GEW));
        pew_pend_d = enter_gew ? 1'b0 : (pew_pend_q || ped_ew);
        pns_pend_d = enter_gns ? 1'b0 : (pns_pend_q || ped_ns);

        if (enter_gew) walk_ew_d = pew_pend_q || ped_ew;
        else           walk_ew_d = walk_ew_q && !walk_done && (state_d == GEW);
        if (enter_gns) walk_ns_d = pns_pend_q || ped_ns;
        else           walk_ns_d = walk_ns_q && !walk_done && (state_d == GNS);

        case (state_d)
            GNS:     lights_d = 6'b100001;
            YNS:     lights_d = 6'b010001;
            RNS:     lights_d = 6'b001001;
            GEW:     lights_d = 6'b001100;
            YEW:     lights_d = 6'b001010;
            REW:     lights_d = 6'b001001;
            default: lights_d = 6'b100001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= GNS;
            presc_q    <= '0;
            sec_cnt_q  <= '0;
            ew_pend_q  <= 1'b0;
            pns_pend_q <= 1'b0;
            pew_pend_q <= 1'b0;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
            lights_q   <= 6'b100001;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_cnt_q  <= sec_cnt_d;
            ew_pend_q  <= ew_pend_d;
            pns_pend_q <= pns_pend_d;
            pew_pend_q <= pew_pend_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
            lights_q   <= lights_d;
        end
    end

    assign lights   = lights_q;
    assign walk_ns  = walk_ns_q;
    assign walk_ew  = walk_ew_q;
    assign phase    = state_q;
    assign sec_tick = tick;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with TICK_DIV=4; edge 0 is the
// first rising edge with reset_n high, and outputs are sampled 1ns after edges.
module tb_intersection_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       car_ew;
    logic       ped_ns;
    logic       ped_ew;
    logic [5:0] lights;
    logic       walk_ns;
    logic       walk_ew;
    logic [2:0] phase;
    logic       sec_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    intersection_scheduler #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .car_ew   (car_ew),
        .ped_ns   (ped_ns),
        .ped_ew   (ped_ew),
        .lights   (lights),
        .walk_ns  (walk_ns),
        .walk_ew  (walk_ew),
        .phase    (phase),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        car_ew  = 1'b0;
        ped_ns  = 1'b0;
        ped_ew  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc     = -1;
    endtask

    task automatic check_state(input string tag, input int at, input logic [2:0] ph,
                               input logic [5:0] lt);
        run_to(at);
        check({tag, "_phase"}, 32'(phase), 32'(ph));
        check({tag, "_lights"}, 32'(lights), 32'(lt));
    endtask

    initial begin
        // Rest hold
        do_reset();
        check("rst_lights", 32'(lights), 32'h21);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_walk_ns", 32'(walk_ns), 32'd0);
        check("rst_walk_ew", 32'(walk_ew), 32'd0);
        check("rst_tick", 32'(sec_tick), 32'd0);
        for (int c = 0; c < 400; c++) begin
            run_to(c);
            check("rest_lights", 32'(lights), 32'h21);
            check("rest_tick", 32'(sec_tick), 32'((c % 4) == 2));
            check("rest_walk", 32'({walk_ns, walk_ew}), 32'd0);
        end

        // Early car request: car pulse at edge 5
        do_reset();
        run_to(4); car_ew = 1'b1;
        run_to(5); car_ew = 1'b0;
        check_state("car_gns_hold", 39, 3'd0, 6'b100001);
        check_state("car_yns_in",   40, 3'd1, 6'b010001);
        check_state("car_yns_end",  47, 3'd1, 6'b010001);
        check_state("car_rns_in",   48, 3'd2, 6'b001001);
        check_state("car_rns_end",  51, 3'd2, 6'b001001);
        check_state("car_gew_in",   52, 3'd3, 6'b001100);
        check_state("car_gew_end",  71, 3'd3, 6'b001100);
        check_state("car_yew_in",   72, 3'd4, 6'b001010);
        check_state("car_yew_end",  79, 3'd4, 6'b001010);
        check_state("car_rew_in",   80, 3'd5, 6'b001001);
        check_state("car_rew_end",  83, 3'd5, 6'b001001);
        check_state("car_gns_back", 84, 3'd0, 6'b100001);
        check_state("car_gns_rest", 200, 3'd0, 6'b100001);

        // EW green extension: car held high
        do_reset();
        car_ew = 1'b1;
        check_state("ext_yns_in",  40, 3'd1, 6'b010001);
        check_state("ext_gew_in",  52, 3'd3, 6'b001100);
        check_state("ext_gew_mid", 90, 3'd3, 6'b001100);
        check_state("ext_gew_end", 111, 3'd3, 6'b001100);
        check_state("ext_yew_in",  112, 3'd4, 6'b001010);
        check_state("ext_gns_in",  124, 3'd0, 6'b100001);
        check_state("ext_gns_end", 164, 3'd0, 6'b100001);
        check_state("ext_yns2_in", 165, 3'd1, 6'b010001);
        car_ew = 1'b0;

        // Pedestrian walk: ped_ew in GNS, ped_ns in GEW
        do_reset();
        run_to(9);  ped_ew = 1'b1;
        run_to(10); ped_ew = 1'b0;
        run_to(51); check("pew_pre", 32'(walk_ew), 32'd0);
        run_to(52); check("pew_on", 32'(walk_ew), 32'd1);
        check("pew_phase", 32'(phase), 32'd3);
        run_to(59); ped_ns = 1'b1;
        run_to(60); ped_ns = 1'b0;
        run_to(67); check("pew_last", 32'(walk_ew), 32'd1);
        check("pew_ns_mid", 32'(walk_ns), 32'd0);
        run_to(68); check("pew_off", 32'(walk_ew), 32'd0);
        check_state("pns_gew_end", 71, 3'd3, 6'b001100);
        run_to(83); check("pns_pre", 32'(walk_ns), 32'd0);
        run_to(84); check("pns_on", 32'(walk_ns), 32'd1);
        check("pns_phase", 32'(phase), 32'd0);
        run_to(99);  check("pns_last", 32'(walk_ns), 32'd1);
        run_to(100); check("pns_off", 32'(walk_ns), 32'd0);
        check_state("pns_rest", 200, 3'd0, 6'b100001);
        check("pns_rest_ew", 32'(walk_ew), 32'd0);

        // Reset mid-operation in GEW with walk_ew high and a pns request pending
        do_reset();
        run_to(9);  ped_ew = 1'b1;
        run_to(10); ped_ew = 1'b0;
        run_to(52); ped_ns = 1'b1;
        run_to(53); ped_ns = 1'b0; car_ew = 1'b1;
        run_to(54); car_ew = 1'b0;
        run_to(55); check("mid_walk_ew", 32'(walk_ew), 32'd1);
        check("mid_phase", 32'(phase), 32'd3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc = -1;
        check("mrst_lights", 32'(lights), 32'h21);
        check("mrst_phase", 32'(phase), 32'd0);
        check("mrst_walk_ew", 32'(walk_ew), 32'd0);
        check("mrst_walk_ns", 32'(walk_ns), 32'd0);
        check("mrst_tick", 32'(sec_tick), 32'd0);
        check_state("mrst_no_pend", 100, 3'd0, 6'b100001);
        check("mrst_walk_ns2", 32'(walk_ns), 32'd0);

        // Set/clear collision: ped_ew on the GEW entry edge
        do_reset();
        run_to(4);  car_ew = 1'b1;
        run_to(5);  car_ew = 1'b0;
        run_to(51); ped_ew = 1'b1;
        run_to(52); ped_ew = 1'b0;
        check("col_walk_on", 32'(walk_ew), 32'd1);
        check("col_phase", 32'(phase), 32'd3);
        run_to(67); check("col_walk_last", 32'(walk_ew), 32'd1);
        run_to(68); check("col_walk_off", 32'(walk_ew), 32'd0);
        check_state("col_gns_back", 84, 3'd0, 6'b100001);
        check_state("col_no_pend", 144, 3'd0, 6'b100001);
        check("col_no_walk", 32'(walk_ew), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
